synthesijer_fconv_x2d_pipe: RTL

Native, fully pipelined integer-to-binary64 converter. Generalises the IP-wrapped long-to-double block: configurable input width, signed or unsigned mode, IEEE round-to-nearest-even, and an inexact flag. There is no vendor IP dependency. It sits behind Synthesijer-generated datapaths using the same `nd`/`valid` strobe convention, and accepts one operand per cycle.

---
 rtl/synthesijer_fconv_x2d_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/synthesijer_fconv_x2d_pipe.sv
// Four-stage integer to IEEE-754 binary64 converter with round-to-nearest-even.
// Signed or unsigned operands of WIDTH bits; nd/valid strobes, no stall.
module synthesijer_fconv_x2d_pipe #(
    parameter int WIDTH  = 64,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             nd,
    output logic [63:0]      result,
    output logic             valid,
    output logic             inexact
);

    // S1: sign and magnitude
    logic        s1_v_q;
    logic        s1_sign_d, s1_sign_q;
    logic [63:0] s1_mag_d,  s1_mag_q;
    // S2: leading-one position
    logic        s2_v_q;
    logic        s2_sign_d, s2_sign_q;
    logic [63:0] s2_mag_d,  s2_mag_q;
    logic [5:0]  s2_p_d,    s2_p_q;
    logic        s2_zero_d, s2_zero_q;
    // S3: normalised mantissa with guard/sticky
    logic        s3_v_q;
    logic        s3_sign_d, s3_sign_q;
    logic [10:0] s3_exp_d,  s3_exp_q;
    logic [51:0] s3_mant_d, s3_mant_q;
    logic        s3_grd_d,  s3_grd_q;
    logic        s3_stk_d,  s3_stk_q;
    logic        s3_zero_d, s3_zero_q;
    // S4: rounded, packed output
    logic        valid_q;
    logic [63:0] result_d,  result_q;
    logic        inexact_d, inexact_q;

    logic             a_neg;
    logic [WIDTH-1:0] mag_w;
    logic [5:0]       lod;
    logic [62:0]      norm;
    logic             round_up;
    logic [52:0]      mant_sum;
    logic [10:0]      exp_r;

    always_comb begin
        a_neg     = (SIGNED != 0) && a[WIDTH-1];
        mag_w     = a_neg ? (~a + WIDTH'(1)) : a;
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        if (nd) begin
            s1_sign_d = a_neg;
            s1_mag_d  = 64'(mag_w);
        end
    end

    always_comb begin
        lod = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (s1_mag_q[i]) lod = 6'(i);
        end
        s2_sign_d = s2_sign_q;
        s2_mag_d  = s2_mag_q;
        s2_p_d    = s2_p_q;
        s2_zero_d = s2_zero_q;
        if (s1_v_q) begin
            s2_sign_d = s1_sign_q;
            s2_mag_d  = s1_mag_q;
            s2_p_d    = lod;
            s2_zero_d = ~|s1_mag_q;
        end
    end

    // The leading 1 lands on bit 63 after the shift and is implicit, so it is dropped.
    always_comb begin
        norm      = 63'(s2_mag_q << (6'd63 - s2_p_q));
        s3_sign_d = s3_sign_q;
        s3_exp_d  = s3_exp_q;
        s3_mant_d = s3_mant_q;
        s3_grd_d  = s3_grd_q;
        s3_stk_d  = s3_stk_q;
        s3_zero_d = s3_zero_q;
        if (s2_v_q) begin
            s3_sign_d = s2_sign_q;
            s3_exp_d  = 11'd1023 + {5'd0, s2_p_q};
            s3_mant_d = norm[62:11];
            s3_grd_d  = norm[10];
            s3_stk_d  = |norm[9:0];
            s3_zero_d = s2_zero_q;
        end
    end

    always_comb begin
        round_up  = s3_grd_q & (s3_stk_q | s3_mant_q[0]);
        mant_sum  = {1'b0, s3_mant_q} + {52'd0, round_up};
        exp_r     = mant_sum[52] ? (s3_exp_q + 11'd1) : s3_exp_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        if (s3_v_q) begin
            result_d  = s3_zero_q ? 64'd0 : {s3_sign_q, exp_r, mant_sum[51:0]};
            inexact_d = ~s3_zero_q & (s3_grd_q | s3_stk_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            valid_q   <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= 64'd0;
            s2_sign_q <= 1'b0;
            s2_mag_q  <= 64'd0;
            s2_p_q    <= 6'd0;
            s2_zero_q <= 1'b0;
            s3_sign_q <= 1'b0;
            s3_exp_q  <= 11'd0;
            s3_mant_q <= 52'd0;
            s3_grd_q  <= 1'b0;
            s3_stk_q  <= 1'b0;
            s3_zero_q <= 1'b0;
            result_q  <= 64'd0;
            inexact_q <= 1'b0;
        end else begin
            s1_v_q    <= nd;
            s2_v_q    <= s1_v_q;
            s3_v_q    <= s2_v_q;
            valid_q   <= s3_v_q;
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s2_sign_q <= s2_sign_d;
            s2_mag_q  <= s2_mag_d;
            s2_p_q    <= s2_p_d;
            s2_zero_q <= s2_zero_d;
            s3_sign_q <= s3_sign_d;
            s3_exp_q  <= s3_exp_d;
            s3_mant_q <= s3_mant_d;
            s3_grd_q  <= s3_grd_d;
            s3_stk_q  <= s3_stk_d;
            s3_zero_q <= s3_zero_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
        end
    end

    assign result  = result_q;
    assign valid   = valid_q;
    assign inexact = inexact_q;

endmodule
